// File: rtl/semaforo_sequenciador_if.sv
// Request/lamp bundle between the grant controller side and the lamp sequencer.
// The master drives the time base and grants. The slave drives the lamps and status.
interface semaforo_sequenciador_if;
  logic       tick;
  logic       n_s;
  logic       l_o;
  logic       ns_verde;
  logic       ns_amarelo;
  logic       ns_vermelho;
  logic       lo_verde;
  logic       lo_amarelo;
  logic       lo_vermelho;
  logic [2:0] estado;
  logic       erro;

  modport master (
    output tick, n_s, l_o,
    input  ns_verde, ns_amarelo, ns_vermelho,
    input  lo_verde, lo_amarelo, lo_vermelho,
    input  estado, erro
  );

  modport slave (
    input  tick, n_s, l_o,
    output ns_verde, ns_amarelo, ns_vermelho,
    output lo_verde, lo_amarelo, lo_vermelho,
    output estado, erro
  );
endinterface

// File: rtl/semaforo_sequenciador.sv
// Lamp sequencer: turns direction grants into green -> yellow -> all-red -> opposite green.
// Dwell times are counted in time-base ticks.
module semaforo_sequenciador #(
  parameter int T_VERDE_MIN = 5,
  parameter int T_AMARELO   = 3,
  parameter int T_VERMELHO  = 1,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  semaforo_sequenciador_if.slave  bus
);
  typedef enum logic [2:0] {
    INIT        = 3'd0,
    NS_VERDE    = 3'd1,
    NS_AMARELO  = 3'd2,
    NS_VERMELHO = 3'd3,
    LO_VERDE    = 3'd4,
    LO_AMARELO  = 3'd5,
    LO_VERMELHO = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LD_VERDE    = CNT_W'(T_VERDE_MIN);
  localparam logic [CNT_W-1:0] LD_AMARELO  = CNT_W'(T_AMARELO);
  localparam logic [CNT_W-1:0] LD_VERMELHO = CNT_W'(T_VERMELHO);

  state_t           r_state, w_nxt_state, w_tgt_state;
  logic [CNT_W-1:0] r_timer, w_nxt_timer, w_load;
  logic             r_erro;
  logic             w_zero, w_go, w_ns_req, w_lo_req;

  assign w_zero   = (r_timer == '0);
  assign w_ns_req = bus.n_s & ~bus.l_o;
  assign w_lo_req = ~bus.n_s & bus.l_o;

  always_comb begin
    w_tgt_state = r_state;
    w_load      = r_timer;
    w_go        = 1'b0;
    case (r_state)
      INIT: begin
        if (w_ns_req) begin
          w_tgt_state = NS_VERDE;
          w_load      = LD_VERDE;
          w_go        = w_zero;
        end else if (w_lo_req) begin
          w_tgt_state = LO_VERDE;
          w_load      = LD_VERDE;
          w_go        = w_zero;
        end
      end
      NS_VERDE: begin
        w_tgt_state = NS_AMARELO;
        w_load      = LD_AMARELO;
        w_go        = w_zero & w_lo_req;
      end
      NS_AMARELO: begin
        w_tgt_state = NS_VERMELHO;
        w_load      = LD_VERMELHO;
        w_go        = w_zero;
      end
      NS_VERMELHO: begin
        w_tgt_state = LO_VERDE;
        w_load      = LD_VERDE;
        w_go        = w_zero;
      end
      LO_VERDE: begin
        w_tgt_state = LO_AMARELO;
        w_load      = LD_AMARELO;
        w_go        = w_zero & w_ns_req;
      end
      LO_AMARELO: begin
        w_tgt_state = LO_VERMELHO;
        w_load      = LD_VERMELHO;
        w_go        = w_zero;
      end
      LO_VERMELHO: begin
        w_tgt_state = NS_VERDE;
        w_load      = LD_VERDE;
        w_go        = w_zero;
      end
      // Unreachable encoding: recover regardless of the timer.
      default: begin
        w_tgt_state = INIT;
        w_load      = LD_VERMELHO;
        w_go        = 1'b1;
      end
    endcase

    w_nxt_state = r_state;
    w_nxt_timer = r_timer;
    if (w_go) begin
      w_nxt_state = w_tgt_state;
      w_nxt_timer = w_load;
    end else if (bus.tick && !w_zero) begin
      w_nxt_timer = r_timer - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_timer <= LD_VERMELHO;
      r_erro  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_timer <= w_nxt_timer;
      r_erro  <= (bus.n_s == bus.l_o);
    end
  end

  // Moore lamp decode. Every state without a green or yellow shows red on both axes.
  always_comb begin
    bus.ns_verde    = (r_state == NS_VERDE);
    bus.ns_amarelo  = (r_state == NS_AMARELO);
    bus.lo_verde    = (r_state == LO_VERDE);
    bus.lo_amarelo  = (r_state == LO_AMARELO);
    bus.ns_vermelho = !(bus.ns_verde || bus.ns_amarelo);
    bus.lo_vermelho = !(bus.lo_verde || bus.lo_amarelo);
    bus.estado      = r_state;
    bus.erro        = r_erro;
  end
endmodule

// File: tb/tb_semaforo_sequenciador.sv
// Table-driven bench for the lamp sequencer.
// Expected state, lamps and erro are queued at drive time and popped after each edge.
module tb_semaforo_sequenciador;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  semaforo_sequenciador_if bus ();
  semaforo_sequenciador dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Lamp order is {ns_verde, ns_amarelo, ns_vermelho, lo_verde, lo_amarelo, lo_vermelho}.
  localparam logic [5:0] RED = 6'b001001;
  localparam logic [5:0] NSV = 6'b100001;
  localparam logic [5:0] NSA = 6'b010001;
  localparam logic [5:0] LOV = 6'b001100;
  localparam logic [5:0] LOA = 6'b001010;

  typedef struct {
    logic       rst_n, tick, n_s, l_o;
    int         reps;
    logic [2:0] est;
    logic [5:0] lamps;
    logic       erro;
  } vec_t;

  typedef struct {
    int         idx;
    logic [9:0] val;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;
  int   vidx = 0;

  exp_t       mon_x;
  logic [9:0] mon_act;
  logic [5:0] mon_l;

  function automatic logic [5:0] lamps_now();
    return {bus.ns_verde, bus.ns_amarelo, bus.ns_vermelho,
            bus.lo_verde, bus.lo_amarelo, bus.lo_vermelho};
  endfunction

  function automatic void add(logic r, logic t, logic ns, logic lo, int reps,
                              logic [2:0] est, logic [5:0] lmp, logic e);
    vec_t v;
    v.rst_n = r; v.tick = t; v.n_s = ns; v.l_o = lo; v.reps = reps;
    v.est = est; v.lamps = lmp; v.erro = e;
    tbl.push_back(v);
  endfunction

  task automatic run_tbl();
    exp_t x;
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        @(negedge clk);
        rst_n    = tbl[i].rst_n;
        bus.tick = tbl[i].tick;
        bus.n_s  = tbl[i].n_s;
        bus.l_o  = tbl[i].l_o;
        x.idx = vidx;
        x.val = {tbl[i].est, tbl[i].lamps, tbl[i].erro};
        sb.push_back(x);
      end
      vidx++;
    end
    tbl.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (sb.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL drain: %0d results pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon_l = lamps_now();
    if (((mon_l[5] | mon_l[4]) & (mon_l[2] | mon_l[1])) != 1'b0) begin
      nmis++;
      $display("FAIL lamp_invariant: lamps %b, green/yellow on both axes", mon_l);
    end
    if (sb.size() > 0) begin
      mon_x   = sb.pop_front();
      mon_act = {bus.estado, mon_l, bus.erro};
      nvec++;
      if (mon_act !== mon_x.val) begin
        nmis++;
        $display("FAIL vec%0d {estado,lamps,erro}: got %b_%b_%b required %b_%b_%b",
                 mon_x.idx, mon_act[9:7], mon_act[6:1], mon_act[0],
                 mon_x.val[9:7], mon_x.val[6:1], mon_x.val[0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bus.tick = 1'b1; bus.n_s = 1'b1; bus.l_o = 1'b0;

    // Reset, release, and the NS_VERDE entry on the second edge after release.
    add(0,1,1,0, 3, 0,RED,0);
    add(1,1,1,0, 1, 0,RED,0);
    add(1,1,1,0, 1, 1,NSV,0);
    // Steady grant.
    add(1,1,1,0,30, 1,NSV,0);
    // Full swap with the green already expired.
    add(1,1,0,1, 4, 2,NSA,0);
    add(1,1,0,1, 2, 3,RED,0);
    add(1,1,0,1, 1, 4,LOV,0);
    add(1,1,0,1, 5, 4,LOV,0);
    add(1,1,1,0, 4, 5,LOA,0);
    add(1,1,1,0, 2, 6,RED,0);
    // Early swap: request at E3 and yellow first at E6 after entry.
    add(1,1,1,0, 1, 1,NSV,0);
    add(1,1,1,0, 2, 1,NSV,0);
    add(1,1,0,1, 3, 1,NSV,0);
    add(1,1,0,1, 4, 2,NSA,0);
    add(1,1,0,1, 2, 3,RED,0);
    add(1,1,0,1, 1, 4,LOV,0);
    // Swap request withdrawn before expiry: green held.
    add(1,1,1,0, 2, 4,LOV,0);
    add(1,1,0,1,10, 4,LOV,0);
    // Invalid pairs: erro follows one edge later and the state holds.
    add(1,1,1,1, 3, 4,LOV,1);
    add(1,1,0,1, 1, 4,LOV,0);
    add(1,1,0,0, 1, 4,LOV,1);
    add(1,1,0,1, 1, 4,LOV,0);
    // Back to NS, then yellow with tick pulsed every 4th cycle.
    add(1,1,1,0, 4, 5,LOA,0);
    add(1,1,1,0, 2, 6,RED,0);
    add(1,1,1,0, 1, 1,NSV,0);
    add(1,1,1,0, 5, 1,NSV,0);
    add(1,0,0,1, 1, 2,NSA,0);
    for (int g = 0; g < 3; g++) begin
      add(1,0,0,1, 3, 2,NSA,0);
      add(1,1,0,1, 1, 2,NSA,0);
    end
    add(1,0,0,1, 1, 3,RED,0);
    // tick low freezes the clearance timer.
    add(1,0,0,1,10, 3,RED,0);
    add(1,1,0,1, 1, 3,RED,0);
    add(1,1,0,1, 1, 4,LOV,0);
    // Walk into the middle of NS_AMARELO.
    add(1,1,0,1, 5, 4,LOV,0);
    add(1,1,1,0, 4, 5,LOA,0);
    add(1,1,1,0, 2, 6,RED,0);
    add(1,1,1,0, 1, 1,NSV,0);
    add(1,1,1,0, 5, 1,NSV,0);
    add(1,1,0,1, 2, 2,NSA,0);
    run_tbl();
    drain();

    // Asynchronous reset mid-yellow, checked before any further clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({bus.estado, lamps_now()} !== {3'd0, RED}) begin
      nmis++;
      $display("FAIL async_reset: got estado=%0d lamps=%b required estado=0 lamps=%b",
               bus.estado, lamps_now(), RED);
    end

    // erro is cleared under reset. An invalid pair holds INIT, then a valid grant goes straight to LO.
    add(0,1,1,1, 2, 0,RED,0);
    add(1,1,1,1, 3, 0,RED,1);
    add(1,1,0,1, 1, 4,LOV,0);
    run_tbl();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
